hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Stall and flush generator. It handles the hazards that operand forwarding cannot resolve.
- Two hazard sources:
  - a load in EXE feeding a branch/JALR that resolves in ID;
  - a multi-cycle DIV/REM occupying EXE.
- Sits beside the forwarding logic in the 5-stage RV32IMC pipeline. It drives the PC/IF-ID/ID-EXE/EXE-MEM hold, bubble and kill controls.

Parameters:
- DIV_CYCLES, 8, total cycles a DIV/REM instruction resides in EXE; legal range 2..255.
- CNT_W, 8, width of the divide countdown counter; must hold DIV_CYCLES-2.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- id_rsA  in  5  rs1 index of instruction in ID.
- id_rsB  in  5  rs2 index of instruction in ID.
- id_use_A  in  1  ID instruction reads rs1 as a register.
- id_use_B  in  1  ID instruction reads rs2 as a register.
- id_is_jump_ctrl  in  1  ID instruction is a conditional branch or JALR (operands consumed in ID).
- id_jump_taken  in  1  ID redirect (taken branch, JAL, JALR) this cycle.
- exe_rd  in  5  destination of EXE instruction.
- exe_wr_en  in  1  EXE instruction writes rd.
- exe_sel_data  in  2  EXE writeback source; 2'd3 = load.
- exe_is_div  in  1  EXE holds a valid DIV/DIVU/REM/REMU.
- if_stall  out  1  hold PC and IF/ID.
- id_stall  out  1  hold ID/EXE input latch of ID instruction.
- exe_stall  out  1  hold ID/EXE register (EXE instruction stays).
- id_bubble  out  1  zero control fields entering EXE.
- exe_bubble  out  1  zero control fields entering MEM.
- if_flush  out  1  kill IF/ID (wrong-path fetch).
- div_busy  out  1  registered; high while in DIV_BUSY.

Behaviour:
- Reset:
  - Synchronous, active-low; one clock; reset is synchronous and active-low.
  - While nrst=0, every output is forced 0.
  - On the next edge: state=IDLE, cnt=0.
  - Reset mid-divide aborts the countdown; outputs are 0 in the cycle after deassertion unless inputs re-trigger.
- FSM states: IDLE, DIV_BUSY.
- Load-use detection (combinational):
  - luse = exe_wr_en && exe_sel_data==2'd3 && exe_rd!=0 && id_is_jump_ctrl && ((id_use_A && id_rsA==exe_rd) || (id_use_B && id_rsB==exe_rd)).
  - In IDLE with luse: if_stall=id_stall=id_bubble=1 for exactly 1 cycle. The next cycle the load is in MEM and its datamem output is forwarded.
  - No stall for a load feeding non-jump instructions; EXE-stage forwarding covers those.
- IDLE with exe_is_div:
  - Assert if_stall, id_stall, exe_stall, exe_bubble.
  - cnt<=DIV_CYCLES-2; go to DIV_BUSY.
- DIV_BUSY:
  - If cnt!=0: same four outputs high; cnt<=cnt-1.
  - If cnt==0: all stalls low (release cycle; DIV result leaves EXE at this edge); go to IDLE.
  - DIV residence in EXE = DIV_CYCLES cycles; stalled cycles = DIV_CYCLES-1.
  - exe_is_div is ignored inside DIV_BUSY, so there is no retrigger.
  - Back-to-back DIVs: second DIV is seen in IDLE the cycle after release.
- Priority:
  - A divide stall dominates. luse cannot coincide with a divide, since EXE holds a non-load.
  - If it appears structurally, the divide outputs win and id_bubble=0.
- Flush:
  - if_flush = id_jump_taken && !if_stall.
  - A redirect during any stall is suppressed; it reissues when ID repeats.
- exe_rd==0 or exe_wr_en=0 never stalls.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Adds output stall_cycles[31:0] and output luse_events[15:0].
  - stall_cycles increments on each cycle with if_stall=1; luse_events increments per load-use stall.
  - Both counters saturate at all-ones and are cleared by reset.
- HAZ_PERF_CNT_EN undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding (IDLE=1'b0, DIV_BUSY=1'b1);
  - SEL_DATA_LOAD=2'd3;
  - DIV_CYCLES default.
- Natural sub-module: hazard_div_timer (counter plus FSM, outputs stall request and release). Load-use compare stays inline.

Test Plan:
- LW x5 in EXE, BEQ x5,x0 in ID (use_A) -> if_stall/id_stall/id_bubble=1 for one cycle, 0 next cycle; if_flush=0 during stall.
- LW x5 in EXE, ADD x6,x5,x1 in ID (not jump) -> no stall; LW with exe_rd=0 plus JALR x0 -> no stall.
- DIV in EXE, DIV_CYCLES=8 -> exe_stall/exe_bubble high 7 cycles, low on 8th; div_busy high cycles 2-8.
- Two consecutive DIVs -> 7 stall cycles, 1 release cycle, 7 stall cycles; no merged or missed countdown.
- id_jump_taken=1 during DIV stall -> if_flush=0; same ID instruction after release with id_jump_taken=1 -> if_flush=1.
- nrst low at cycle 3 of DIV -> all outputs 0 during reset, div_busy=0 after; with HAZ_PERF_CNT_EN, stall_cycles returns to 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller slice.
package hazard_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    localparam logic [1:0]  SEL_DATA_LOAD  = 2'd3;
    localparam int unsigned DIV_CYCLES_DEF = 8;

endpackage

// File: rtl/hazard_div_timer.sv
// Divide occupancy timer: holds the pipeline while a DIV/REM sits in EXE,
// then signals a single release cycle.
module hazard_div_timer
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic exe_is_div,
    output logic div_stall,
    output logic div_release,
    output logic div_busy
);

    // The entry cycle is stalled from IDLE, so the countdown covers the rest.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (exe_is_div) begin
                    state_next = DIV_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_stall   = 1'b0;
        div_release = 1'b0;
        div_busy    = 1'b0;
        if (nrst) begin
            case (state)
                IDLE: div_stall = exe_is_div;
                DIV_BUSY: begin
                    div_busy    = 1'b1;
                    div_stall   = (cnt != '0);
                    div_release = (cnt == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush generator for load->branch and multi-cycle divide hazards.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [4:0] id_rsA,
    input  logic [4:0] id_rsB,
    input  logic       id_use_A,
    input  logic       id_use_B,
    input  logic       id_is_jump_ctrl,
    input  logic       id_jump_taken,
    input  logic [4:0] exe_rd,
    input  logic       exe_wr_en,
    input  logic [1:0] exe_sel_data,
    input  logic       exe_is_div,
    output logic       if_stall,
    output logic       id_stall,
    output logic       exe_stall,
    output logic       id_bubble,
    output logic       exe_bubble,
    output logic       if_flush,
    output logic       div_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] luse_events
`endif
);

    logic div_stall;
    logic div_release;
    logic luse;
    logic luse_stall;

    hazard_div_timer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_timer (
        .clk         (clk),
        .nrst        (nrst),
        .exe_is_div  (exe_is_div),
        .div_stall   (div_stall),
        .div_release (div_release),
        .div_busy    (div_busy)
    );

    always_comb begin
        luse = exe_wr_en && (exe_sel_data == SEL_DATA_LOAD) && (exe_rd != 5'd0) &&
               id_is_jump_ctrl &&
               ((id_use_A && (id_rsA == exe_rd)) || (id_use_B && (id_rsB == exe_rd)));
        // Load-use only acts in IDLE with no divide entering; the divide wins otherwise.
        luse_stall = nrst && luse && !div_stall && !div_release;

        if_stall   = div_stall || luse_stall;
        id_stall   = div_stall || luse_stall;
        exe_stall  = div_stall;
        id_bubble  = luse_stall;
        exe_bubble = div_stall;
        if_flush   = nrst && id_jump_taken && !if_stall;
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cycles <= '0;
            luse_events  <= '0;
        end else begin
            if (if_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (luse_stall && (luse_events != '1)) begin
                luse_events <= luse_events + 16'd1;
            end
        end
    end
`endif

endmodule
